// File: rtl/cpu_periph_link_if.sv
// cpu_periph_link_if: observable signals of the CPU/peripheral send-ack link.
//   estadoCPU        - CPU FSM state register (4 bits)
//   estadoPeriferico - peripheral FSM state register (4 bits)
//   dados            - data word driven by the CPU side (4 bits)
//   send             - CPU request, data valid
//   ack              - peripheral acknowledge
//   dadosPeriferico  - last word captured by the peripheral (4 bits)
// The master modport is used by the link itself, which drives every signal.
// The slave modport is for observers such as monitors.
interface cpu_periph_link_if;
  logic [3:0] estadoCPU;
  logic [3:0] estadoPeriferico;
  logic [3:0] dados;
  logic       send;
  logic       ack;
  logic [3:0] dadosPeriferico;

  modport master (
    output estadoCPU,
    output estadoPeriferico,
    output dados,
    output send,
    output ack,
    output dadosPeriferico
  );

  modport slave (
    input estadoCPU,
    input estadoPeriferico,
    input dados,
    input send,
    input ack,
    input dadosPeriferico
  );
endinterface

// File: rtl/cpu_periph_link.sv
// cpu_periph_link: a CPU-side transmitter FSM and a peripheral-side receiver FSM.
// They exchange an incrementing 4-bit word over a four-phase send/ack handshake.
// Ports:
//   clk  - rising-edge clock shared by both FSMs
//   rst  - synchronous, active-low reset
//   link - cpu_periph_link_if.master. It carries both state registers, the data
//          word, send, ack and the word captured by the peripheral. All of these
//          are registered outputs.
module cpu_periph_link (
  input  logic                clk,
  input  logic                rst,
  cpu_periph_link_if.master   link
);

  typedef enum logic [3:0] {
    CpuIdle = 4'd0,
    CpuSend = 4'd1,
    CpuWait = 4'd2,
    CpuNext = 4'd3
  } cpu_state_e;

  typedef enum logic [3:0] {
    PerIdle = 4'd0,
    PerAck  = 4'd1
  } per_state_e;

  cpu_state_e cpu_state_q, cpu_state_d;
  per_state_e per_state_q, per_state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] dados_q, dados_d;
  logic       send_q, send_d;
  logic       ack_q, ack_d;
  logic [3:0] dperiph_q, dperiph_d;

  // CPU side: the counter advances only once ack has dropped. This means the
  // next word is never presented while the peripheral still holds the old one.
  always_comb begin
    cpu_state_d = cpu_state_q;
    send_d      = send_q;
    dados_d     = dados_q;
    cnt_d       = cnt_q;
    case (cpu_state_q)
      CpuIdle: begin
        cpu_state_d = CpuSend;
        send_d      = 1'b1;
        dados_d     = cnt_q;
      end
      CpuSend: begin
        if (ack_q) begin
          send_d      = 1'b0;
          cpu_state_d = CpuWait;
        end
      end
      CpuWait: begin
        if (!ack_q) begin
          cnt_d       = cnt_q + 4'd1;
          cpu_state_d = CpuNext;
        end
      end
      CpuNext: begin
        send_d      = 1'b1;
        dados_d     = cnt_q;
        cpu_state_d = CpuSend;
      end
      default: begin
        send_d      = 1'b0;
        cpu_state_d = CpuIdle;
      end
    endcase
  end

  // Peripheral side: the word is captured in the same cycle that ack is raised.
  always_comb begin
    per_state_d = per_state_q;
    ack_d       = ack_q;
    dperiph_d   = dperiph_q;
    case (per_state_q)
      PerIdle: begin
        if (send_q) begin
          dperiph_d   = dados_q;
          ack_d       = 1'b1;
          per_state_d = PerAck;
        end
      end
      PerAck: begin
        if (!send_q) begin
          ack_d       = 1'b0;
          per_state_d = PerIdle;
        end
      end
      default: begin
        ack_d       = 1'b0;
        per_state_d = PerIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_state_q <= CpuIdle;
      per_state_q <= PerIdle;
      cnt_q       <= 4'd0;
      dados_q     <= 4'd0;
      send_q      <= 1'b0;
      ack_q       <= 1'b0;
      dperiph_q   <= 4'd0;
    end else begin
      cpu_state_q <= cpu_state_d;
      per_state_q <= per_state_d;
      cnt_q       <= cnt_d;
      dados_q     <= dados_d;
      send_q      <= send_d;
      ack_q       <= ack_d;
      dperiph_q   <= dperiph_d;
    end
  end

  assign link.estadoCPU        = cpu_state_q;
  assign link.estadoPeriferico = per_state_q;
  assign link.dados            = dados_q;
  assign link.send             = send_q;
  assign link.ack              = ack_q;
  assign link.dadosPeriferico  = dperiph_q;

endmodule

// File: tb/tb_cpu_periph_link.sv
// tb_cpu_periph_link: randomized reset/run segments for cpu_periph_link.
// At each release the stimulus pushes the expected captures (word k at edge
// E(2+5k)) into a scoreboard queue. A monitor pops an entry on every ack rise.
// The monitor also compares each edge against a trace derived from the edge
// index, and checks the handshake rules.
module tb_cpu_periph_link;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  cpu_periph_link_if link ();

  cpu_periph_link dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  typedef struct {
    int         edge_n;
    logic [3:0] val;
  } cap_t;

  cap_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected outputs after edge E(n); n = 0 means a reset edge. From E2 on,
  // the link repeats a 5-cycle pattern that carries word w = (n-2)/5.
  function automatic void model(input int n, output int cpu, output int per,
                                output int dd, output int dp, output int sd,
                                output int ak);
    int p;
    int w;
    cpu = 0; per = 0; dd = 0; dp = 0; sd = 0; ak = 0;
    if (n == 1) begin
      cpu = 1;
      sd  = 1;
    end else if (n >= 2) begin
      p   = (n - 2) % 5;
      w   = (n - 2) / 5;
      dp  = w % 16;
      dd  = (p == 4) ? (w + 1) % 16 : w % 16;
      sd  = (p == 0 || p == 4) ? 1 : 0;
      ak  = (p < 2) ? 1 : 0;
      per = ak;
      cpu = (p == 0 || p == 4) ? 1 : (p == 3) ? 3 : 2;
    end
  endfunction

  // Monitor
  initial begin
    int   n = 0;
    logic r;
    int   cpu, per, dd, dp, sd, ak;
    logic p_send = 1'b0;
    logic p_ack = 1'b0;
    logic [3:0] p_dados = 4'd0;
    cap_t e;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (!r) n = 0;
      else n++;
      model(n, cpu, per, dd, dp, sd, ak);
      check($sformatf("estadoCPU@E%0d", n), int'(link.estadoCPU), cpu);
      check($sformatf("estadoPeriferico@E%0d", n), int'(link.estadoPeriferico), per);
      check($sformatf("dados@E%0d", n), int'(link.dados), dd);
      check($sformatf("dadosPeriferico@E%0d", n), int'(link.dadosPeriferico), dp);
      check($sformatf("send@E%0d", n), int'(link.send), sd);
      check($sformatf("ack@E%0d", n), int'(link.ack), ak);
      if (r) begin
        if (p_send && !p_ack) check("send_held_until_ack", int'(link.send), 1);
        if (p_send && link.send) check("dados_stable", int'(link.dados), int'(p_dados));
        if (!p_send && !p_ack) check("ack_only_after_send", int'(link.ack), 0);
        if (p_ack && !p_send) check("send_no_rise_on_ack", int'(link.send), 0);
        check("cpu_state_range", int'(link.estadoCPU <= 4'd3), 1);
        check("per_state_range", int'(link.estadoPeriferico <= 4'd1), 1);
        if (link.ack && !p_ack) begin
          if (exp_q.size() == 0) begin
            check("capture_unexpected_edge", n, -1);
          end else begin
            e = exp_q.pop_front();
            check("capture_edge", n, e.edge_n);
            check("capture_value", int'(link.dadosPeriferico), int'(e.val));
          end
        end
      end
      p_send  = link.send;
      p_ack   = link.ack;
      p_dados = link.dados;
    end
  end

  // Hold reset for `hold` edges, then run `run` edges with reset released.
  task automatic segment(input int hold, input int run);
    cap_t c;
    rst = 1'b0;
    repeat (hold) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("stale_expectations", exp_q.size(), 0);
      exp_q.delete();
    end
    for (int k = 0; 2 + 5 * k <= run; k++) begin
      c.edge_n = 2 + 5 * k;
      c.val    = 4'(k);
      exp_q.push_back(c);
    end
    rst = 1'b1;
    repeat (run) @(negedge clk);
  endtask

  initial begin
    segment(3, 100);   // long run covering the wrap from word 15 to word 0 at E82
    segment(1, 3);     // reset lands mid-handshake (send=0, ack=1)
    segment(1, 20);
    for (int i = 0; i < 6; i++) begin
      segment(int'($urandom_range(1, 3)), int'($urandom_range(1, 40)));
    end
    rst = 1'b0;
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
